fip_div_seq: RTL and testbench

Parametrised, iterative signed fixed-point divider. It is the sequential successor to the combinational `fip_32_div`. It computes one quotient bit per cycle and generalises word width and fraction width, with fixed latency, a start/busy/valid handshake, and explicit divide-by-zero and overflow flags. It sits in the ray-intersection datapath wherever a Q-format divide is needed off the critical path, for example in barycentric normalisation and reciprocal terms.

---
 rtl/fip_pkg.sv | 27 ++
 rtl/fip_sat.sv | 57 +++++
 rtl/fip_div_seq.sv | 186 ++++++++++++++++++
 tb/tb_fip_div_seq.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/fip_pkg.sv
// fip_pkg: shared definitions for the iterative fixed-point operators.
// Holds the divider state encoding, the TRUE/FALSE constants and helpers
// that build the most positive / most negative bit patterns of a w-bit
// two's-complement word. The helpers return 64 bits; callers keep the
// low w bits, so they are valid for w <= 64.
package fip_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_FIX  = 2'd2
  } fip_state_e;

  // Largest positive value of a w-bit signed word (0x7F..F).
  function automatic logic [63:0] fip_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Most negative value of a w-bit signed word (0x80..0).
  function automatic logic [63:0] fip_min(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/fip_sat.sv
// fip_sat: sign / range / divide-by-zero resolution for an unsigned
// N-bit magnitude result of an iterative operator.
//   i_mag  : unsigned result magnitude (N bits)
//   i_sign : 1 = result is negative
//   i_dbz  : 1 = divide by zero; sign then selects MAX (0) / MIN (1)
//   o_z    : WIDTH-bit signed result
//   o_ovf  : magnitude does not fit the signed WIDTH-bit range
// Purely combinational; the caller registers the outputs.
module fip_sat
  import fip_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 48,
  parameter bit SAT   = 1'b1
) (
  input  logic [N-1:0]     i_mag,
  input  logic             i_sign,
  input  logic             i_dbz,
  output logic [WIDTH-1:0] o_z,
  output logic             o_ovf
);

  localparam logic [WIDTH-1:0] W_MAX = WIDTH'(fip_max(WIDTH));
  localparam logic [WIDTH-1:0] W_MIN = WIDTH'(fip_min(WIDTH));

  logic [WIDTH-1:0] w_low;
  logic [WIDTH-1:0] w_wrap;
  logic [WIDTH-1:0] w_limit;
  logic             w_hi_nz;
  logic             w_range_ovf;

  // Range check, wrap value and final result selection.
  always_comb begin
    w_low   = i_mag[WIDTH-1:0];
    // Low bits of the negated magnitude equal the negation of the low bits.
    w_wrap  = i_sign ? (~w_low + {{(WIDTH-1){1'b0}}, 1'b1}) : w_low;
    w_hi_nz = |i_mag[N-1:WIDTH];
    // Negative results may reach exactly 2^(W-1); positive ones stop one short.
    if (i_sign) begin
      w_range_ovf = w_hi_nz | (i_mag[WIDTH-1] & (|i_mag[WIDTH-2:0]));
    end else begin
      w_range_ovf = w_hi_nz | i_mag[WIDTH-1];
    end
    w_limit = i_sign ? W_MIN : W_MAX;
    if (i_dbz) begin
      o_z   = w_limit;
      o_ovf = FALSE;
    end else if (w_range_ovf && (SAT == TRUE)) begin
      o_z   = w_limit;
      o_ovf = TRUE;
    end else begin
      o_z   = w_wrap;
      o_ovf = w_range_ovf;
    end
  end

endmodule

// File: rtl/fip_div_seq.sv
// fip_div_seq: iterative signed fixed-point divider, one quotient bit per
// cycle (restoring radix-2 on magnitudes), z = x / y in Q(WIDTH-FRA_BITS).FRA_BITS.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_en         : start; accepted when idle
//   i_x, i_y     : signed dividend / divisor, sampled on accept
//   o_z          : signed quotient, held until the next result
//   o_busy       : operation in flight
//   o_valid      : one-cycle pulse when o_z/o_dbz/o_ovf are updated
//   o_dbz, o_ovf : divide-by-zero / out-of-range flags, held with o_z
// Latency from accept edge to o_valid is WIDTH+FRA_BITS+2 cycles.
module fip_div_seq
  import fip_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int FRA_BITS = 16,
  parameter bit SAT      = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  output logic [WIDTH-1:0] o_z,
  output logic             o_busy,
  output logic             o_valid,
  output logic             o_dbz,
  output logic             o_ovf
);

  localparam int N  = WIDTH + FRA_BITS;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

  fip_state_e r_state;
  fip_state_e w_state_nxt;

  logic             r_sign;
  logic             r_dbz;
  logic [WIDTH-1:0] r_ymag;
  logic [N-1:0]     r_dvd;
  logic [WIDTH:0]   r_rem;
  logic [N-1:0]     r_quo;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH-1:0] r_z;
  logic             r_busy;
  logic             r_valid;
  logic             r_dbz_out;
  logic             r_ovf;

  logic [WIDTH-1:0] w_xmag;
  logic [WIDTH-1:0] w_ymag;
  logic [WIDTH+1:0] w_rem_sh;
  logic [WIDTH+1:0] w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_sat_z;
  logic             w_sat_ovf;
  logic             w_busy_nxt;
  logic             w_valid_nxt;

  // Operand magnitudes and the restoring trial subtraction.
  always_comb begin
    // |FIP_MIN| = 2^(W-1) is still representable as a W-bit unsigned value.
    w_xmag   = i_x[WIDTH-1] ? (~i_x + {{(WIDTH-1){1'b0}}, 1'b1}) : i_x;
    w_ymag   = i_y[WIDTH-1] ? (~i_y + {{(WIDTH-1){1'b0}}, 1'b1}) : i_y;
    w_rem_sh = {r_rem, r_dvd[N-1]};
    // The top bit of w_rem_sh is always 0, so the diff MSB is a clean borrow.
    w_diff   = w_rem_sh - {2'b00, r_ymag};
    w_ge     = ~w_diff[WIDTH+1];
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_en) w_state_nxt = ST_DIV;
        else      w_state_nxt = ST_IDLE;
      end
      ST_DIV: begin
        if (r_cnt == CNT_ZERO) w_state_nxt = ST_FIX;
        else                   w_state_nxt = ST_DIV;
      end
      ST_FIX:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered handshake outputs.
  always_comb begin
    w_busy_nxt = (w_state_nxt != ST_IDLE);
    if (r_state == ST_FIX) w_valid_nxt = TRUE;
    else                   w_valid_nxt = FALSE;
  end

  // Operand capture and one restoring step per DIV cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sign <= 1'b0;
      r_dbz  <= 1'b0;
      r_ymag <= {WIDTH{1'b0}};
      r_dvd  <= {N{1'b0}};
      r_rem  <= {(WIDTH+1){1'b0}};
      r_quo  <= {N{1'b0}};
      r_cnt  <= CNT_ZERO;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_en) begin
            r_sign <= i_x[WIDTH-1] ^ i_y[WIDTH-1];
            r_dbz  <= (i_y == {WIDTH{1'b0}});
            r_ymag <= w_ymag;
            r_dvd  <= {w_xmag, {FRA_BITS{1'b0}}};
            r_rem  <= {(WIDTH+1){1'b0}};
            r_quo  <= {N{1'b0}};
            r_cnt  <= CNT_LAST;
          end else begin
            r_cnt  <= r_cnt;
          end
        end
        ST_DIV: begin
          // With |y| = 0 this runs unchanged; fip_sat ignores the quotient.
          r_dvd <= {r_dvd[N-2:0], 1'b0};
          r_rem <= w_ge ? w_diff[WIDTH:0] : w_rem_sh[WIDTH:0];
          r_quo <= {r_quo[N-2:0], w_ge};
          r_cnt <= r_cnt - {{(CW-1){1'b0}}, 1'b1};
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  fip_sat #(
    .WIDTH (WIDTH),
    .N     (N),
    .SAT   (SAT)
  ) u_sat (
    .i_mag  (r_quo),
    .i_sign (r_sign),
    .i_dbz  (r_dbz),
    .o_z    (w_sat_z),
    .o_ovf  (w_sat_ovf)
  );

  // Registered outputs; result and flags load only on the valid pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_z       <= {WIDTH{1'b0}};
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_dbz_out <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_busy  <= w_busy_nxt;
      r_valid <= w_valid_nxt;
      if (w_valid_nxt) begin
        r_z       <= w_sat_z;
        r_dbz_out <= r_dbz;
        r_ovf     <= w_sat_ovf;
      end else begin
        r_z       <= r_z;
        r_dbz_out <= r_dbz_out;
        r_ovf     <= r_ovf;
      end
    end
  end

  assign o_z     = r_z;
  assign o_busy  = r_busy;
  assign o_valid = r_valid;
  assign o_dbz   = r_dbz_out;
  assign o_ovf   = r_ovf;

endmodule

// File: tb/tb_fip_div_seq.sv
// tb_fip_div_seq: directed self-checking bench for fip_div_seq.
// Three instances: 32/16 saturating (d=0), 32/16 wrapping (d=1), 16/8 (d=2).
// Inputs are driven and outputs sampled on the falling edge.
module tb_fip_div_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst_v;
  logic [2:0]  en_v;
  logic [31:0] x0, y0, x1, y1;
  logic [15:0] x2, y2;
  logic [31:0] z0, z1;
  logic [15:0] z2;
  logic [2:0]  bsy, vld, dbz, ovf;

  int n_tests = 0;
  int n_fail  = 0;

  fip_div_seq #(.WIDTH(32), .FRA_BITS(16), .SAT(1'b1)) u_dut0 (
    .i_clk(clk), .i_rst(rst_v[0]), .i_en(en_v[0]), .i_x(x0), .i_y(y0),
    .o_z(z0), .o_busy(bsy[0]), .o_valid(vld[0]), .o_dbz(dbz[0]), .o_ovf(ovf[0])
  );

  fip_div_seq #(.WIDTH(32), .FRA_BITS(16), .SAT(1'b0)) u_dut1 (
    .i_clk(clk), .i_rst(rst_v[1]), .i_en(en_v[1]), .i_x(x1), .i_y(y1),
    .o_z(z1), .o_busy(bsy[1]), .o_valid(vld[1]), .o_dbz(dbz[1]), .o_ovf(ovf[1])
  );

  fip_div_seq #(.WIDTH(16), .FRA_BITS(8), .SAT(1'b1)) u_dut2 (
    .i_clk(clk), .i_rst(rst_v[2]), .i_en(en_v[2]), .i_x(x2), .i_y(y2),
    .o_z(z2), .o_busy(bsy[2]), .o_valid(vld[2]), .o_dbz(dbz[2]), .o_ovf(ovf[2])
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int d, input logic e, input logic [31:0] x, input logic [31:0] y);
    case (d)
      0: begin x0 = x; y0 = y; end
      1: begin x1 = x; y1 = y; end
      default: begin x2 = x[15:0]; y2 = y[15:0]; end
    endcase
    en_v[d] = e;
  endtask

  function automatic logic [31:0] zof(input int d);
    case (d)
      0:       return z0;
      1:       return z1;
      default: return {16'h0000, z2};
    endcase
  endfunction

  // Start an op and wait (bounded) for o_valid. lat is the cycle label k of
  // the valid sample, counting the cycle right after the accept edge as 1;
  // nbusy counts busy samples up to and including that cycle.
  task automatic do_op(input int d, input logic [31:0] x, input logic [31:0] y,
                       input bit now, input int pulse_k,
                       output logic [31:0] z, output logic dz, output logic ov,
                       output int lat, output int nbusy);
    if (!now) @(negedge clk);
    drive(d, 1'b1, x, y);
    @(negedge clk);
    // Operands are free to change once accepted.
    drive(d, 1'b0, 32'hDEAD_BEEF, 32'h1357_9BDF);
    lat = 0; nbusy = 0; z = 32'h0; dz = 1'b0; ov = 1'b0;
    for (int k = 1; k <= 120; k++) begin
      if (k == pulse_k) drive(d, 1'b1, 32'h0001_0000, 32'h0001_0000);
      else              en_v[d] = 1'b0;
      if (bsy[d]) nbusy++;
      if (vld[d]) begin
        lat = k; z = zof(d); dz = dbz[d]; ov = ovf[d];
        break;
      end
      @(negedge clk);
    end
    en_v[d] = 1'b0;
  endtask

  task automatic run_chk(input string tag, input int d, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] exp_z,
                         input logic exp_dz, input logic exp_ov);
    logic [31:0] z;
    logic        dz, ov;
    int          lat, nb, exp_lat;
    exp_lat = (d == 2) ? 26 : 50;
    do_op(d, x, y, 1'b0, 0, z, dz, ov, lat, nb);
    chk({tag, "_z"},     64'(z),          64'(exp_z));
    chk({tag, "_flags"}, 64'({dz, ov}),   64'({exp_dz, exp_ov}));
    chk({tag, "_lat"},   64'(lat),        64'(exp_lat));
    chk({tag, "_busy"},  64'(nb),         64'(exp_lat - 1));
    @(negedge clk);
    chk({tag, "_hold"},  64'({vld[d], zof(d)}), 64'({1'b0, exp_z}));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] z;
    logic        dz, ov;
    int          lat, nb, seen;

    rst_v = 3'b111; en_v = 3'b000;
    x0 = 32'h0; y0 = 32'h0; x1 = 32'h0; y1 = 32'h0; x2 = 16'h0; y2 = 16'h0;
    repeat (3) @(negedge clk);
    chk("reset_d0", 64'({z0, bsy[0], vld[0], dbz[0], ovf[0]}), 64'd0);
    chk("reset_d2", 64'({z2, bsy[2], vld[2], dbz[2], ovf[2]}), 64'd0);
    rst_v = 3'b000;

    // Normal quotients.
    run_chk("two_by_two", 0, 32'h0002_0000, 32'h0002_0000, 32'h0001_0000, 1'b0, 1'b0);
    run_chk("raw_2_3",    0, 32'h0000_0002, 32'h0000_0003, 32'h0000_AAAA, 1'b0, 1'b0);
    run_chk("half_qtr",   0, 32'h0000_8000, 32'h0000_4000, 32'h0002_0000, 1'b0, 1'b0);
    run_chk("neg1_half",  0, 32'hFFFF_0000, 32'h0000_8000, 32'hFFFE_0000, 1'b0, 1'b0);

    // Range boundaries and overflow.
    run_chk("max_qtr",    0, 32'h7FFF_FFFF, 32'h0000_4000, 32'h7FFF_FFFF, 1'b0, 1'b1);
    run_chk("min_qtr",    0, 32'h8000_0000, 32'h0000_4000, 32'h8000_0000, 1'b0, 1'b1);
    run_chk("min_neg1",   0, 32'h8000_0000, 32'hFFFF_0000, 32'h7FFF_FFFF, 1'b0, 1'b1);
    run_chk("min_one",    0, 32'h8000_0000, 32'h0001_0000, 32'h8000_0000, 1'b0, 1'b0);
    run_chk("max_one",    0, 32'h7FFF_FFFF, 32'h0001_0000, 32'h7FFF_FFFF, 1'b0, 1'b0);
    run_chk("wrap_max_qtr",  1, 32'h7FFF_FFFF, 32'h0000_4000, 32'hFFFF_FFFC, 1'b0, 1'b1);
    run_chk("wrap_min_neg1", 1, 32'h8000_0000, 32'hFFFF_0000, 32'h8000_0000, 1'b0, 1'b1);

    // Divide by zero, then a normal op clears the flag.
    run_chk("dbz_pos",   0, 32'h0001_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0);
    run_chk("dbz_neg",   0, 32'hFFFF_0000, 32'h0000_0000, 32'h8000_0000, 1'b1, 1'b0);
    run_chk("dbz_clear", 0, 32'h0006_0000, 32'h0002_0000, 32'h0003_0000, 1'b0, 1'b0);

    // 16/8 instance.
    run_chk("q8_3_1p5",    2, 32'h0000_0300, 32'h0000_0180, 32'h0000_0200, 1'b0, 1'b0);
    run_chk("q8_neg3_1p5", 2, 32'h0000_FD00, 32'h0000_0180, 32'h0000_FE00, 1'b0, 1'b0);

    // Start request while busy is ignored.
    do_op(0, 32'h0006_0000, 32'h0003_0000, 1'b0, 5, z, dz, ov, lat, nb);
    chk("ignore_en_z",   64'(z),   64'h0000_0000_0002_0000);
    chk("ignore_en_lat", 64'(lat), 64'd50);

    // Back-to-back: second start in the valid cycle of the first.
    do_op(0, 32'h0001_0000, 32'h0004_0000, 1'b0, 0, z, dz, ov, lat, nb);
    chk("b2b_first_z", 64'(z), 64'h0000_0000_0000_4000);
    do_op(0, 32'h0003_0000, 32'h0001_0000, 1'b1, 0, z, dz, ov, lat, nb);
    chk("b2b_second_z",   64'(z),   64'h0000_0000_0003_0000);
    chk("b2b_second_lat", 64'(lat), 64'd50);

    // Reset mid-operation aborts; o_z (holding 0x30000) must clear too.
    @(negedge clk);
    drive(0, 1'b1, 32'h0005_0000, 32'h0001_0000);
    @(negedge clk);
    drive(0, 1'b0, 32'h0, 32'h0);
    repeat (9) @(negedge clk);
    rst_v[0] = 1'b1;
    @(negedge clk);
    rst_v[0] = 1'b0;
    chk("rst_abort_outs", 64'({z0, bsy[0], vld[0], dbz[0], ovf[0]}), 64'd0);
    seen = 0;
    for (int k = 12; k <= 60; k++) begin
      @(negedge clk);
      if (vld[0]) seen++;
    end
    chk("rst_no_valid", 64'(seen), 64'd0);
    run_chk("after_rst", 0, 32'h0005_0000, 32'h0001_0000, 32'h0005_0000, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
